mpu_frame_assembler: RTL and testbench

Periodic sample scheduler and frame assembler for the MPU-6050 read path, sitting directly downstream of `std_iic_master`. After sensor initialisation, it issues a one-cycle `read_now` request to the master at a fixed sample rate. It then collects the 14-byte burst returned on `data`/`data_avalid` (registers 0x3B–0x48) and publishes seven signed 16-bit axis words atomically, with a valid strobe. It also detects timeouts and request overruns.

---
 rtl/mpu_frame_pkg.sv | 30 +++
 rtl/sample_tick_gen.sv | 30 +++
 rtl/mpu_frame_assembler.sv | 145 ++++++++++++++
 tb/tb_mpu_frame_assembler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_frame_pkg.sv
// Shared definitions for the MPU-6050 frame assembler: FSM states and the
// position of every register byte inside the 14-byte burst (0x3B..0x48).
package mpu_frame_pkg;

   localparam int NBYTES = 14;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_TICK = 2'd1,
      ST_COLLECT   = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   // Burst byte positions; each axis word is {H, L}
   localparam int AX_H = 0;
   localparam int AX_L = 1;
   localparam int AY_H = 2;
   localparam int AY_L = 3;
   localparam int AZ_H = 4;
   localparam int AZ_L = 5;
   localparam int T_H  = 6;
   localparam int T_L  = 7;
   localparam int GX_H = 8;
   localparam int GX_L = 9;
   localparam int GY_H = 10;
   localparam int GY_L = 11;
   localparam int GZ_H = 12;
   localparam int GZ_L = 13;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider. Counts 0..SAMPLE_PERIOD-1 while enabled
// and flags the last count; held at zero while disabled.
module sample_tick_gen #(
   parameter int SAMPLE_PERIOD = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int            CW   = $clog2(SAMPLE_PERIOD);
   localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

   logic [CW-1:0] cnt;

   // Period counter: cleared by reset or when disabled, wraps after LAST
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/mpu_frame_assembler.sv
// Periodic burst-read scheduler and 14-byte frame assembler for the MPU-6050.
// Requests a burst from the I2C master every sample period, gathers the bytes
// into a shadow buffer and publishes all seven axis words at once.
//
// Byte interface: data_avalid is a one-cycle strobe with no back-pressure;
// data is meaningful only in a cycle where data_avalid is high, and every such
// byte is consumed in that cycle (or ignored outside COLLECT).
module mpu_frame_assembler #(
   parameter int SAMPLE_PERIOD = 50000,
   parameter int TIMEOUT       = 40000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init_done,
   input  logic               data_avalid,
   input  logic [7:0]         data,
   output logic               read_now,
   output logic signed [15:0] accel_x,
   output logic signed [15:0] accel_y,
   output logic signed [15:0] accel_z,
   output logic signed [15:0] temp,
   output logic signed [15:0] gyro_x,
   output logic signed [15:0] gyro_y,
   output logic signed [15:0] gyro_z,
   output logic               frame_valid,
   output logic               frame_err,
   output logic [7:0]         overrun_cnt
);

   import mpu_frame_pkg::*;

   localparam int            TW          = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT);
   localparam logic [3:0]    LAST_IDX    = 4'(NBYTES - 1);

   state_t        state;
   logic          tick;
   logic [3:0]    idx;
   logic [TW-1:0] to_cnt;
   logic          last_byte;
   logic [7:0]    shadow      [NBYTES];
   logic [7:0]    frame_bytes [NBYTES];

   sample_tick_gen #(
      .SAMPLE_PERIOD(SAMPLE_PERIOD)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (init_done),
      .tick (tick)
   );

   assign last_byte = (state == ST_COLLECT) && data_avalid && (idx == LAST_IDX);

   // Complete frame as it will look once the byte arriving now is stored
   always_comb begin
      frame_bytes       = shadow;
      frame_bytes[GZ_L] = data;
   end

   // Shadow capture of each burst byte at its running index
   always_ff @(posedge clk) begin
      if (state == ST_COLLECT && init_done && data_avalid) begin
         shadow[idx] <= data;
      end
   end

   // Sequencer: tick -> request -> collect -> publish, plus timeout and overrun tracking.
   // The output words are loaded on the edge that enters DONE so they are
   // visible together with frame_valid during the DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         idx         <= '0;
         to_cnt      <= '0;
         read_now    <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         overrun_cnt <= '0;
         accel_x     <= '0;
         accel_y     <= '0;
         accel_z     <= '0;
         temp        <= '0;
         gyro_x      <= '0;
         gyro_y      <= '0;
         gyro_z      <= '0;
      end else begin
         read_now    <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;

         // A tick that cannot start a read is dropped and counted
         if (tick && state != ST_WAIT_TICK && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
         end

         if (!init_done) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_WAIT_TICK;
               end
               ST_WAIT_TICK: begin
                  if (tick) begin
                     read_now <= 1'b1;
                     idx      <= '0;
                     to_cnt   <= '0;
                     state    <= ST_COLLECT;
                  end
               end
               ST_COLLECT: begin
                  if (data_avalid) begin
                     idx <= idx + 4'd1;
                  end
                  // Last byte beats a simultaneous timeout
                  if (last_byte) begin
                     accel_x     <= {frame_bytes[AX_H], frame_bytes[AX_L]};
                     accel_y     <= {frame_bytes[AY_H], frame_bytes[AY_L]};
                     accel_z     <= {frame_bytes[AZ_H], frame_bytes[AZ_L]};
                     temp        <= {frame_bytes[T_H],  frame_bytes[T_L]};
                     gyro_x      <= {frame_bytes[GX_H], frame_bytes[GX_L]};
                     gyro_y      <= {frame_bytes[GY_H], frame_bytes[GY_L]};
                     gyro_z      <= {frame_bytes[GZ_H], frame_bytes[GZ_L]};
                     frame_valid <= 1'b1;
                     state       <= ST_DONE;
                  end else if (to_cnt == TIMEOUT_VAL) begin
                     frame_err <= 1'b1;
                     state     <= ST_WAIT_TICK;
                  end else begin
                     to_cnt <= to_cnt + TW'(1);
                  end
               end
               ST_DONE: begin
                  state <= ST_WAIT_TICK;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mpu_frame_assembler.sv
// Bench for mpu_frame_assembler. Main instance: period 100, timeout 80.
// Second instance: period 100, timeout 150, never fed bytes, runs alongside
// to exercise overrun counting up to saturation.
module tb_mpu_frame_assembler;

   localparam int P   = 100;
   localparam int TO  = 80;
   localparam int TO2 = 150;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- main DUT ----------------
   logic               init_done = 1'b0;
   logic               data_avalid = 1'b0;
   logic [7:0]         data = 8'h00;
   logic               read_now, frame_valid, frame_err;
   logic signed [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
   logic [7:0]         overrun_cnt;

   mpu_frame_assembler #(.SAMPLE_PERIOD(P), .TIMEOUT(TO)) u_dut (
      .clk(clk), .rst(rst), .init_done(init_done), .data_avalid(data_avalid), .data(data),
      .read_now(read_now), .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
      .temp(temp), .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
      .frame_valid(frame_valid), .frame_err(frame_err), .overrun_cnt(overrun_cnt)
   );

   // ---------------- overrun DUT ----------------
   logic               init2 = 1'b0;
   logic               dav2 = 1'b0;
   logic [7:0]         data2 = 8'h00;
   logic               read2, fv2, fe2;
   logic signed [15:0] ax2, ay2, az2, t2, gx2, gy2, gz2;
   logic [7:0]         ovr2;

   mpu_frame_assembler #(.SAMPLE_PERIOD(P), .TIMEOUT(TO2)) u_dut_ovr (
      .clk(clk), .rst(rst2), .init_done(init2), .data_avalid(dav2), .data(data2),
      .read_now(read2), .accel_x(ax2), .accel_y(ay2), .accel_z(az2),
      .temp(t2), .gyro_x(gx2), .gyro_y(gy2), .gyro_z(gz2),
      .frame_valid(fv2), .frame_err(fe2), .overrun_cnt(ovr2)
   );

   // ---------------- check bookkeeping ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- transaction-level model of the main DUT ----------------
   // Tracks: cycles since init_done rose, whether a burst is in flight, how
   // long it has been in flight, the bytes received, and the last good frame.
   bit          m_live = 1'b0;
   int          m_age = 0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   int          m_elapsed = 0;
   logic [7:0]  m_q[$];
   logic [15:0] m_words [7];
   logic        e_read = 1'b0, e_valid = 1'b0, e_err = 1'b0;
   logic [7:0]  e_ovr = 8'd0;

   always @(posedge clk) begin
      bit tick_now, was_busy, was_done;
      if (rst) begin
         m_live = 1'b1;
         m_age = 0; m_busy = 1'b0; m_done = 1'b0; m_elapsed = 0;
         m_q.delete();
         for (int w = 0; w < 7; w++) m_words[w] = 16'h0000;
         e_read = 1'b0; e_valid = 1'b0; e_err = 1'b0; e_ovr = 8'd0;
      end else begin
         e_read = 1'b0; e_valid = 1'b0; e_err = 1'b0;
         was_busy = m_busy;
         was_done = m_done;
         m_done = 1'b0;
         if (!init_done) begin
            m_age = 0;
            m_busy = 1'b0;
            m_q.delete();
         end else begin
            tick_now = ((m_age % P) == P - 1);
            m_age++;
            if (tick_now) begin
               if (!was_busy && !was_done) begin
                  e_read = 1'b1;
                  m_busy = 1'b1;
                  m_elapsed = 0;
                  m_q.delete();
               end else if (e_ovr != 8'd255) begin
                  e_ovr = e_ovr + 8'd1;
               end
            end
            if (was_busy) begin
               if (data_avalid) m_q.push_back(data);
               if (m_q.size() == 14) begin
                  for (int w = 0; w < 7; w++) m_words[w] = {m_q[2*w], m_q[2*w+1]};
                  e_valid = 1'b1;
                  m_busy = 1'b0;
                  m_done = 1'b1;
               end else if (m_elapsed == TO) begin
                  e_err = 1'b1;
                  m_busy = 1'b0;
               end else begin
                  m_elapsed++;
               end
            end
         end
      end
   end

   // Per-cycle compare of the main DUT against the model
   always @(negedge clk) begin
      if (m_live) begin
         chk("read_now", read_now, e_read);
         chk("frame_valid", frame_valid, e_valid);
         chk("frame_err", frame_err, e_err);
         chk("overrun_cnt", overrun_cnt, e_ovr);
         chk("accel_x", accel_x, m_words[0]);
         chk("accel_y", accel_y, m_words[1]);
         chk("accel_z", accel_z, m_words[2]);
         chk("temp", temp, m_words[3]);
         chk("gyro_x", gyro_x, m_words[4]);
         chk("gyro_y", gyro_y, m_words[5]);
         chk("gyro_z", gyro_z, m_words[6]);
      end
   end

   // Overrun instance: read at 100, 300, ...; error at 251, 451, ...;
   // one dropped tick per 200 cycles, saturating at 255.
   int a2 = 0;
   always @(posedge clk) begin
      if (rst2 || !init2) a2 <= 0;
      else a2 <= a2 + 1;
   end

   always @(negedge clk) begin
      if (!rst2 && init2) begin
         chk("ovr_read_now", read2, (a2 > 0) && (a2 % 200 == 100));
         chk("ovr_frame_err", fe2, (a2 >= 251) && (a2 % 200 == 51));
         chk("ovr_frame_valid", fv2, 1'b0);
         chk("ovr_count", ovr2, (a2 / 200 > 255) ? 16'd255 : 16'(a2 / 200));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic goto_cycle(input int tgt);
      while (cyc < tgt) step();
   endtask

   task automatic send_spaced(input logic [7:0] b);
      data_avalid = 1'b1;
      data = b;
      step();
      data_avalid = 1'b0;
      step();
      step();
   endtask

   task automatic wait_read(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         if (read_now) begin
            at = cyc;
            return;
         end
         step();
      end
      chk("read_now_wait_expired", 1'b0, 1'b1);
   endtask

   task automatic quiet_window(input int n, input string tag);
      int n_rd, n_fe, n_fv;
      n_rd = 0; n_fe = 0; n_fv = 0;
      repeat (n) begin
         step();
         n_rd += int'(read_now);
         n_fe += int'(frame_err);
         n_fv += int'(frame_valid);
      end
      chk({tag, "_read_now_count"}, 16'(n_rd), 16'd0);
      chk({tag, "_frame_err_count"}, 16'(n_fe), 16'd0);
      chk({tag, "_frame_valid_count"}, 16'(n_fv), 16'd0);
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] f1 [14] = '{8'h12, 8'h34, 8'hFF, 8'hFE, 8'h00, 8'h01, 8'h80,
                           8'h00, 8'h7F, 8'hFF, 8'h00, 8'h10, 8'hF0, 8'h00};
   int t0, t1, t2r, t3, t4, t5, tu;

   initial begin
      rst = 1'b1; rst2 = 1'b1;
      repeat (3) step();
      chk("rst_read_now", read_now, 1'b0);
      chk("rst_frame_valid", frame_valid, 1'b0);
      chk("rst_overrun", overrun_cnt, 16'd0);
      chk("rst_accel_x", accel_x, 16'h0000);
      chk("rst_gyro_z", gyro_z, 16'h0000);
      rst = 1'b0; rst2 = 1'b0;
      step();

      // First read_now 100 cycles after init_done rises
      init_done = 1'b1; init2 = 1'b1;
      t0 = cyc;
      wait_read(150, t1);
      chk("first_read_offset", 16'(t1 - t0), 16'd100);
      chk("pre_frame_accel_x", accel_x, 16'h0000);
      chk("pre_frame_temp", temp, 16'h0000);

      // Frame 1: bytes 3 cycles apart
      step();
      for (int i = 0; i < 13; i++) send_spaced(f1[i]);
      data_avalid = 1'b1; data = f1[13];
      step();
      data_avalid = 1'b0;
      chk("f1_valid_after_last", frame_valid, 1'b1);
      chk("f1_accel_x", accel_x, 16'h1234);
      chk("f1_accel_y", accel_y, 16'hFFFE);
      chk("f1_accel_z", accel_z, 16'h0001);
      chk("f1_temp", temp, 16'h8000);
      chk("f1_gyro_x", gyro_x, 16'h7FFF);
      chk("f1_gyro_y", gyro_y, 16'h0010);
      chk("f1_gyro_z", gyro_z, 16'hF000);
      step();
      chk("f1_valid_one_cycle", frame_valid, 1'b0);

      // Short frame: 10 bytes, timeout error 81 cycles after read_now
      wait_read(200, t2r);
      chk("second_read_period", 16'(t2r - t1), 16'd100);
      step();
      for (int i = 0; i < 10; i++) send_spaced(8'h55);
      for (int i = 0; i < 100 && !frame_err; i++) step();
      chk("err_offset", 16'(cyc - t2r), 16'd81);
      chk("err_keeps_accel_x", accel_x, 16'h1234);
      chk("err_keeps_gyro_z", gyro_z, 16'hF000);

      // Next read on schedule; 14th byte exactly when the timeout count hits 80
      wait_read(200, t3);
      chk("read_after_err_period", 16'(t3 - t2r), 16'd100);
      step();
      for (int i = 0; i < 13; i++) begin
         data_avalid = 1'b1; data = 8'hA0 + 8'(i);
         step();
      end
      data_avalid = 1'b0;
      goto_cycle(t3 + 80);
      data_avalid = 1'b1; data = 8'hAD;
      step();
      data_avalid = 1'b0;
      chk("edge_frame_valid", frame_valid, 1'b1);
      chk("edge_frame_err", frame_err, 1'b0);
      chk("edge_accel_x", accel_x, 16'hA0A1);
      chk("edge_temp", temp, 16'hA6A7);
      chk("edge_gyro_z", gyro_z, 16'hACAD);
      step();
      chk("edge_no_late_err", frame_err, 1'b0);

      // init_done drops after 5 bytes
      wait_read(200, t4);
      chk("read_after_edge_period", 16'(t4 - t3), 16'd100);
      step();
      for (int i = 0; i < 5; i++) send_spaced(8'h11);
      init_done = 1'b0;
      quiet_window(250, "init_drop");
      chk("init_drop_keeps_accel_x", accel_x, 16'hA0A1);

      // Re-enable, then reset mid-frame
      init_done = 1'b1;
      tu = cyc;
      wait_read(150, t5);
      chk("reenable_read_offset", 16'(t5 - tu), 16'd100);
      step();
      for (int i = 0; i < 3; i++) send_spaced(8'h22);
      rst = 1'b1; init_done = 1'b0;
      step();
      rst = 1'b0;
      chk("midrst_accel_x", accel_x, 16'h0000);
      chk("midrst_gyro_z", gyro_z, 16'h0000);
      chk("midrst_overrun", overrun_cnt, 16'd0);
      quiet_window(200, "after_reset");

      // Let the overrun instance reach saturation
      while (a2 < 51300) step();
      chk("ovr_saturated", ovr2, 16'd255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #700000;
      errors++;
      $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
